// File: rtl/nova_defines.sv
// Shared CAVLC definitions: FSM state encoding and maxNumCoeff constants
// common to the CAVLC decoding stages.
package nova_defines;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_LAST   = 2'd2,
        ST_DONE   = 2'd3
    } cavlc_state_e;

    localparam logic [4:0] MAX_COEFF_4  = 5'd4;
    localparam logic [4:0] MAX_COEFF_15 = 5'd15;
    localparam logic [4:0] MAX_COEFF_16 = 5'd16;
    localparam int         NUM_COEFF    = 16;

    // Scan position of the highest-frequency coefficient; 15-entry blocks skip index 0 (DC).
    function automatic logic [4:0] first_pos(input logic [4:0] tc,
                                             input logic [3:0] tz,
                                             input logic [4:0] max_coeff);
        logic [4:0] sum;
        sum = tc + {1'b0, tz} + {4'b0000, (max_coeff == MAX_COEFF_15)};
        return sum - 5'd1;
    endfunction

endpackage

// File: rtl/run_before_decoding_lut.sv
// Combinational run_before codeword decoder (H.264 Table 9-10) over the
// first 11 unread bits of the bitstream window.
module run_before_lut (
    input  logic [3:0]  zeros_left,
    input  logic [10:0] window,
    output logic [3:0]  run,
    output logic [3:0]  len,
    output logic        invalid
);

    // Codeword table lookup, one branch per zerosLeft row.
    always_comb begin
        run     = 4'd0;
        len     = 4'd0;
        invalid = 1'b0;
        case (zeros_left)
            4'd0: begin
                run = 4'd0;
                len = 4'd0;
            end
            4'd1: begin
                len = 4'd1;
                run = window[10] ? 4'd0 : 4'd1;
            end
            4'd2: begin
                if (window[10]) begin
                    len = 4'd1;
                    run = 4'd0;
                end else begin
                    len = 4'd2;
                    run = window[9] ? 4'd1 : 4'd2;
                end
            end
            4'd3: begin
                len = 4'd2;
                run = 4'd3 - {2'b00, window[10:9]};
            end
            4'd4: begin
                if (window[10:9] != 2'b00) begin
                    len = 4'd2;
                    run = 4'd3 - {2'b00, window[10:9]};
                end else begin
                    len = 4'd3;
                    run = window[8] ? 4'd3 : 4'd4;
                end
            end
            4'd5: begin
                if (window[10]) begin
                    len = 4'd2;
                    run = window[9] ? 4'd0 : 4'd1;
                end else begin
                    len = 4'd3;
                    run = 4'd5 - {2'b00, window[9:8]};
                end
            end
            4'd6: begin
                if (window[10:9] == 2'b11) begin
                    len = 4'd2;
                    run = 4'd0;
                end else begin
                    len = 4'd3;
                    case (window[10:8])
                        3'b000:  run = 4'd1;
                        3'b001:  run = 4'd2;
                        3'b011:  run = 4'd3;
                        3'b010:  run = 4'd4;
                        3'b101:  run = 4'd5;
                        3'b100:  run = 4'd6;
                        default: run = 4'd0;
                    endcase
                end
            end
            default: begin
                if (window[10:8] != 3'b000) begin
                    len = 4'd3;
                    run = 4'd7 - {1'b0, window[10:8]};
                end else begin
                    // Long codes: (run-4) zeros then a 1, so the 1 position gives the run.
                    casez (window[7:0])
                        8'b1???????: begin run = 4'd7;  len = 4'd4;  end
                        8'b01??????: begin run = 4'd8;  len = 4'd5;  end
                        8'b001?????: begin run = 4'd9;  len = 4'd6;  end
                        8'b0001????: begin run = 4'd10; len = 4'd7;  end
                        8'b00001???: begin run = 4'd11; len = 4'd8;  end
                        8'b000001??: begin run = 4'd12; len = 4'd9;  end
                        8'b0000001?: begin run = 4'd13; len = 4'd10; end
                        8'b00000001: begin run = 4'd14; len = 4'd11; end
                        default: begin
                            run     = 4'd0;
                            len     = 4'd11;
                            invalid = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/run_before_decoding.sv
// CAVLC run_before stage: decodes one run_before codeword per cycle and places
// levels into a 16-entry scan-order array. Optional checks: RUN_BEFORE_ERR_CHECK_EN.
module run_before_decoding
    import nova_defines::*;
#(
    parameter int LEVEL_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4:0]              maxNumCoeff,
    input  logic [4:0]              TotalCoeff,
    input  logic [3:0]              total_zeros,
    input  logic [15:0]             BitStream_buffer_output,
    output logic [3:0]              level_rd_idx,
    input  logic [LEVEL_W-1:0]      level_rd_data,
    output logic [3:0]              run_before_len,
    output logic                    busy,
    output logic                    coeff_valid,
    output logic [16*LEVEL_W-1:0]   coeff_out,
    output logic                    run_error
);

    cavlc_state_e       state_r;
    logic [3:0]         zeros_left_r;
    logic [3:0]         i_r;
    logic [4:0]         pos_r;
    logic [4:0]         tc_r;
    logic [LEVEL_W-1:0] coeff_r [NUM_COEFF];
    logic               coeff_valid_r;
    logic               busy_r;

    logic [3:0]         lut_run_s;
    logic [3:0]         lut_len_s;
    logic               lut_invalid_s;
    logic [3:0]         run_s;
    logic [4:0]         pos_next_s;
    logic [4:0]         start_pos_s;
    logic               last_step_s;
    logic               unused_s;

    run_before_lut u_lut (
        .zeros_left (zeros_left_r),
        .window     (BitStream_buffer_output[15:5]),
        .run        (lut_run_s),
        .len        (lut_len_s),
        .invalid    (lut_invalid_s)
    );

    // Bits past the longest codeword are never examined.
    assign unused_s = ^BitStream_buffer_output[4:0];

    // Per-cycle arithmetic; an undecodable codeword absorbs all remaining zeros.
    always_comb begin
        run_s          = lut_invalid_s ? zeros_left_r : lut_run_s;
        pos_next_s     = pos_r - {1'b0, run_s} - 5'd1;
        start_pos_s    = first_pos(TotalCoeff, total_zeros, maxNumCoeff);
        last_step_s    = ({1'b0, i_r} == (tc_r - 5'd2));
        run_before_len = 4'd0;
        if (state_r == ST_DECODE) begin
            run_before_len = lut_len_s;
        end else begin
            run_before_len = 4'd0;
        end
    end

`ifdef RUN_BEFORE_ERR_CHECK_EN
    logic run_error_r;
    logic start_overflow_s;
    logic pos_underflow_s;

    // Error conditions: oversubscribed block at start, position running below zero.
    always_comb begin
        start_overflow_s = (({1'b0, TotalCoeff} + {2'b00, total_zeros}) > {1'b0, maxNumCoeff});
        pos_underflow_s  = ({1'b0, pos_r} < ({2'b00, run_s} + 6'd1));
    end

    // Sticky error flag, re-armed by each accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_error_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            run_error_r <= start_overflow_s;
        end else if ((state_r == ST_DECODE) && (lut_invalid_s || pos_underflow_s)) begin
            run_error_r <= 1'b1;
        end
    end

    assign run_error = run_error_r;
`else
    assign run_error = 1'b0;
`endif

    // Control FSM, counters and coefficient array.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            zeros_left_r  <= 4'd0;
            i_r           <= 4'd0;
            pos_r         <= 5'd0;
            tc_r          <= 5'd0;
            coeff_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            for (int k = 0; k < NUM_COEFF; k++) begin
                coeff_r[k] <= {LEVEL_W{1'b0}};
            end
        end else begin
            coeff_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_COEFF; k++) begin
                            coeff_r[k] <= {LEVEL_W{1'b0}};
                        end
                        zeros_left_r <= total_zeros;
                        i_r          <= 4'd0;
                        pos_r        <= start_pos_s;
                        tc_r         <= TotalCoeff;
                        if (TotalCoeff == 5'd0) begin
                            state_r       <= ST_DONE;
                            coeff_valid_r <= 1'b1;
                            busy_r        <= 1'b0;
                        end else if (TotalCoeff == 5'd1) begin
                            state_r <= ST_LAST;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_DECODE;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    if (!pos_r[4]) begin
                        coeff_r[pos_r[3:0]] <= level_rd_data;
                    end
                    pos_r        <= pos_next_s;
                    zeros_left_r <= zeros_left_r - run_s;
                    i_r          <= i_r + 4'd1;
                    if (last_step_s) begin
                        state_r <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    if (!pos_r[4]) begin
                        coeff_r[pos_r[3:0]] <= level_rd_data;
                    end
                    state_r       <= ST_DONE;
                    busy_r        <= 1'b0;
                    coeff_valid_r <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign level_rd_idx = i_r;
    assign busy         = busy_r;
    assign coeff_valid  = coeff_valid_r;

    for (genvar g = 0; g < NUM_COEFF; g++) begin : g_flat
        assign coeff_out[g*LEVEL_W +: LEVEL_W] = coeff_r[g];
    end

endmodule

// File: tb/tb_run_before_decoding.sv
// Directed bench for run_before_decoding: emulates the level buffer and the
// bitstream controller, checks lengths, timing and final coefficient arrays.
module tb_run_before_decoding;

    localparam int LW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [4:0]        maxNumCoeff;
    logic [4:0]        TotalCoeff;
    logic [3:0]        total_zeros;
    logic [15:0]       BitStream_buffer_output;
    logic [3:0]        level_rd_idx;
    logic [LW-1:0]     level_rd_data;
    logic [3:0]        run_before_len;
    logic              busy;
    logic              coeff_valid;
    logic [16*LW-1:0]  coeff_out;
    logic              run_error;

    logic [0:255]      stream;
    int                ptr = 0;
    int                base;
    logic [LW-1:0]     levels [16];
    logic [LW-1:0]     exp_c  [16];
    int                len_log  [20];
    logic              busy_log [20];
    int                idx_log  [20];
    int                valid_cyc;
    int                pulses;
    int                total_cnt = 0;
    int                bad_cnt = 0;
    logic              exp_err;

    run_before_decoding #(.LEVEL_W(LW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .maxNumCoeff             (maxNumCoeff),
        .TotalCoeff              (TotalCoeff),
        .total_zeros             (total_zeros),
        .BitStream_buffer_output (BitStream_buffer_output),
        .level_rd_idx            (level_rd_idx),
        .level_rd_data           (level_rd_data),
        .run_before_len          (run_before_len),
        .busy                    (busy),
        .coeff_valid             (coeff_valid),
        .coeff_out               (coeff_out),
        .run_error               (run_error)
    );

    always #5 clk = ~clk;

    assign level_rd_data           = levels[level_rd_idx];
    assign BitStream_buffer_output = stream[ptr +: 16];

    // Bitstream controller: advance by the bits consumed this cycle.
    always @(posedge clk) ptr <= ptr + int'(run_before_len);

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        if (obs !== expv) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_bits(input logic [15:0] bits, input int n);
        for (int k = 0; k < 32; k++) stream[ptr + k] = (k < n) ? bits[n - 1 - k] : 1'b0;
    endtask

    task automatic clr_exp();
        for (int k = 0; k < 16; k++) exp_c[k] = 16'h0000;
    endtask

    task automatic chk_coeffs(input string tag);
        for (int k = 0; k < 16; k++)
            chk_val($sformatf("%s_c%0d", tag, k), {16'h0000, coeff_out[k*LW +: LW]}, {16'h0000, exp_c[k]});
    endtask

    task automatic run_block(input logic [4:0] tc, input logic [3:0] tz, input logic [4:0] mx);
        @(negedge clk);
        TotalCoeff = tc; total_zeros = tz; maxNumCoeff = mx; start = 1'b1;
        base = ptr; valid_cyc = -1; pulses = 0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            len_log[c] = int'(run_before_len); busy_log[c] = busy; idx_log[c] = int'(level_rd_idx);
            if (coeff_valid) begin
                pulses++;
                if (valid_cyc < 0) valid_cyc = c;
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; maxNumCoeff = 5'd16; TotalCoeff = 5'd0; total_zeros = 4'd0;
        stream = '0;
        for (int k = 0; k < 16; k++) levels[k] = 16'h0000;
`ifdef RUN_BEFORE_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_val("rst_valid", coeff_valid, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_err", run_error, 0);
        chk_val("rst_idx", level_rd_idx, 0);
        chk_val("rst_len", run_before_len, 0);
        chk_val("rst_array", |coeff_out, 0);
        reset = 1'b0;

        // TC=3 tz=2: codes "1" then "01"
        levels[0] = 16'd5; levels[1] = 16'hFFFE; levels[2] = 16'd1;
        load_bits(16'b101, 3);
        run_block(5'd3, 4'd2, 5'd16);
        chk_val("a_len1", len_log[1], 1);
        chk_val("a_len2", len_log[2], 2);
        chk_val("a_len_last", len_log[3], 0);
        chk_val("a_busy1", busy_log[1], 1);
        chk_val("a_busy3", busy_log[3], 1);
        chk_val("a_busy4", busy_log[4], 0);
        chk_val("a_idx_last", idx_log[3], 2);
        chk_val("a_valid_cyc", valid_cyc, 4);
        chk_val("a_pulses", pulses, 1);
        chk_val("a_bits", ptr - base, 3);
        clr_exp(); exp_c[4] = 16'd5; exp_c[3] = 16'hFFFE; exp_c[1] = 16'd1;
        chk_coeffs("a");

        // TC=0: immediate completion, array cleared
        load_bits(16'h0000, 16);
        run_block(5'd0, 4'd0, 5'd16);
        chk_val("b_valid_cyc", valid_cyc, 1);
        chk_val("b_pulses", pulses, 1);
        chk_val("b_bits", ptr - base, 0);
        chk_val("b_busy1", busy_log[1], 0);
        clr_exp();
        chk_coeffs("b");

        // TC=1 tz=15: LAST only
        levels[0] = 16'd7;
        run_block(5'd1, 4'd15, 5'd16);
        chk_val("c_valid_cyc", valid_cyc, 2);
        chk_val("c_bits", ptr - base, 0);
        chk_val("c_idx1", idx_log[1], 0);
        clr_exp(); exp_c[15] = 16'd7;
        chk_coeffs("c");

        // max=15 TC=2 tz=13: start pos 15, code "0000000001" = run 13
        levels[0] = 16'd3; levels[1] = 16'd9;
        load_bits(16'b0000000001, 10);
        run_block(5'd2, 4'd13, 5'd15);
        chk_val("d_len1", len_log[1], 10);
        chk_val("d_valid_cyc", valid_cyc, 3);
        chk_val("d_err", run_error, 0);
        clr_exp(); exp_c[15] = 16'd3; exp_c[1] = 16'd9;
        chk_coeffs("d");

        // zl=7 three-bit code "001" = run 6
        levels[0] = 16'd21; levels[1] = 16'd22;
        load_bits(16'b001, 3);
        run_block(5'd2, 4'd7, 5'd16);
        chk_val("e_len1", len_log[1], 3);
        chk_val("e_valid_cyc", valid_cyc, 3);
        clr_exp(); exp_c[8] = 16'd21; exp_c[1] = 16'd22;
        chk_coeffs("e");

        // zl=6 "101" = run 5, then zl=1 "0" = run 1
        levels[0] = 16'd11; levels[1] = 16'd12; levels[2] = 16'd13;
        load_bits(16'b1010, 4);
        run_block(5'd3, 4'd6, 5'd16);
        chk_val("f_len1", len_log[1], 3);
        chk_val("f_len2", len_log[2], 1);
        chk_val("f_bits", ptr - base, 4);
        clr_exp(); exp_c[8] = 16'd11; exp_c[2] = 16'd12; exp_c[0] = 16'd13;
        chk_coeffs("f");

        // Reset in cycle 2 of a TC=5 decode
        for (int k = 0; k < 5; k++) levels[k] = 16'(k + 1);
        load_bits(16'h0000, 16);
        @(negedge clk);
        TotalCoeff = 5'd5; total_zeros = 4'd0; maxNumCoeff = 5'd16; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk_val("r_pre_c4", coeff_out[4*LW +: LW], 1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk_val("r_busy", busy, 0);
        chk_val("r_array", |coeff_out, 0);
        chk_val("r_idx", level_rd_idx, 0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (coeff_valid) pulses++;
        end
        chk_val("r_no_valid", pulses, 0);
        run_block(5'd5, 4'd0, 5'd16);
        chk_val("r2_valid_cyc", valid_cyc, 6);
        clr_exp(); exp_c[4] = 16'd1; exp_c[3] = 16'd2; exp_c[2] = 16'd3; exp_c[1] = 16'd4; exp_c[0] = 16'd5;
        chk_coeffs("r2");

        // zl=10 with an all-zero window: undecodable codeword
        levels[0] = 16'd31; levels[1] = 16'd32;
        load_bits(16'h0000, 16);
        run_block(5'd2, 4'd10, 5'd16);
        chk_val("g_err", run_error, exp_err);
        chk_val("g_valid_cyc", valid_cyc, 3);
        clr_exp(); exp_c[11] = 16'd31; exp_c[0] = 16'd32;
        chk_coeffs("g");
        repeat (4) @(negedge clk);
        chk_val("g_err_sticky", run_error, exp_err);

        // Next accepted start clears the flag
        levels[0] = 16'd5; levels[1] = 16'hFFFE; levels[2] = 16'd1;
        load_bits(16'b101, 3);
        run_block(5'd3, 4'd2, 5'd16);
        chk_val("h_err_cleared", run_error, 0);
        chk_val("h_valid_cyc", valid_cyc, 4);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
